// File: rtl/alu_op_sequencer_if.sv
// Signal bundle between the sequencer, its requester/consumer and the shared ALU.
// master = environment (requester, consumer, ALU); slave = the sequencer itself.
interface alu_op_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_tag;

    logic [31:0] alu_reg1;
    logic [31:0] alu_reg2;
    logic [3:0]  alu_control;
    logic        alu_inc_pc;
    logic [31:0] alu_z_lo;
    logic [31:0] alu_z_hi;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic [3:0]  rsp_tag;
    logic        rsp_err;

    logic        busy;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag,
        output alu_z_lo, alu_z_hi,
        output rsp_ready,
        input  req_ready,
        input  alu_reg1, alu_reg2, alu_control, alu_inc_pc,
        input  rsp_valid, rsp_lo, rsp_hi, rsp_tag, rsp_err,
        input  busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag,
        input  alu_z_lo, alu_z_hi,
        input  rsp_ready,
        output req_ready,
        output alu_reg1, alu_reg2, alu_control, alu_inc_pc,
        output rsp_valid, rsp_lo, rsp_hi, rsp_tag, rsp_err,
        output busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Serialises ALU operations: holds the ALU inputs for a per-op settle window, captures Z,
// and returns a tagged response over valid/ready. Sole driver of the ALU inputs.
module alu_op_sequencer #(
    parameter int unsigned SIMPLE_WAIT = 2,
    parameter int unsigned MUL_WAIT    = 4,
    parameter int unsigned DIV_WAIT    = 6
) (
    input logic               Clk,
    input logic               Clear,
    alu_op_sequencer_if.slave bus
);
    localparam int unsigned MaxWait =
        (DIV_WAIT > MUL_WAIT) ? ((DIV_WAIT > SIMPLE_WAIT) ? DIV_WAIT : SIMPLE_WAIT)
                              : ((MUL_WAIT > SIMPLE_WAIT) ? MUL_WAIT : SIMPLE_WAIT);
    localparam int unsigned CntW = $clog2(MaxWait + 1);

    localparam logic [3:0] OpDiv   = 4'd0;
    localparam logic [3:0] OpMul   = 4'd1;
    localparam logic [3:0] OpAdd   = 4'd2;
    localparam logic [3:0] OpIncPc = 4'd12;

    typedef enum logic [1:0] {StIdle, StIssue, StExec, StResp} state_e;

    state_e          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [3:0]      tag_q, tag_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     alu_reg1_q, alu_reg1_d;
    logic [31:0]     alu_reg2_q, alu_reg2_d;
    logic [3:0]      alu_control_q, alu_control_d;
    logic            alu_inc_pc_q, alu_inc_pc_d;
    logic [31:0]     rsp_lo_q, rsp_lo_d;
    logic [31:0]     rsp_hi_q, rsp_hi_d;
    logic [3:0]      rsp_tag_q, rsp_tag_d;
    logic            rsp_err_q, rsp_err_d;
    logic            req_illegal;
    logic            op_wide;

    // Rejected requests bypass the ALU entirely so its inputs keep their previous values.
    assign req_illegal = (bus.req_op > OpIncPc) || ((bus.req_op == OpDiv) && (bus.req_b == '0));
    assign op_wide     = (op_q == OpDiv) || (op_q == OpMul);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        tag_d         = tag_q;
        cnt_d         = cnt_q;
        alu_reg1_d    = alu_reg1_q;
        alu_reg2_d    = alu_reg2_q;
        alu_control_d = alu_control_q;
        alu_inc_pc_d  = alu_inc_pc_q;
        rsp_lo_d      = rsp_lo_q;
        rsp_hi_d      = rsp_hi_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_err_d     = rsp_err_q;

        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    op_d  = bus.req_op;
                    tag_d = bus.req_tag;
                    if (req_illegal) begin
                        rsp_lo_d  = '0;
                        rsp_hi_d  = '0;
                        rsp_tag_d = bus.req_tag;
                        rsp_err_d = 1'b1;
                        state_d   = StResp;
                    end else begin
                        // ALU inputs are loaded here so they are already driven during ISSUE.
                        alu_reg1_d    = bus.req_a;
                        alu_reg2_d    = bus.req_b;
                        alu_inc_pc_d  = (bus.req_op == OpIncPc);
                        alu_control_d = (bus.req_op == OpIncPc) ? OpAdd : bus.req_op;
                        state_d       = StIssue;
                    end
                end
            end

            StIssue: begin
                if (op_q == OpDiv) begin
                    cnt_d = CntW'(DIV_WAIT);
                end else if (op_q == OpMul) begin
                    cnt_d = CntW'(MUL_WAIT);
                end else begin
                    cnt_d = CntW'(SIMPLE_WAIT);
                end
                state_d = StExec;
            end

            StExec: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q <= CntW'(1)) begin
                    rsp_lo_d  = bus.alu_z_lo;
                    rsp_hi_d  = op_wide ? bus.alu_z_hi : '0;
                    rsp_tag_d = tag_q;
                    rsp_err_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = StResp;
                end
            end

            StResp: begin
                if (bus.rsp_ready) begin
                    alu_inc_pc_d = 1'b0;
                    state_d      = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clear) begin
            state_q       <= StIdle;
            op_q          <= '0;
            tag_q         <= '0;
            cnt_q         <= '0;
            alu_reg1_q    <= '0;
            alu_reg2_q    <= '0;
            alu_control_q <= '0;
            alu_inc_pc_q  <= 1'b0;
            rsp_lo_q      <= '0;
            rsp_hi_q      <= '0;
            rsp_tag_q     <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            tag_q         <= tag_d;
            cnt_q         <= cnt_d;
            alu_reg1_q    <= alu_reg1_d;
            alu_reg2_q    <= alu_reg2_d;
            alu_control_q <= alu_control_d;
            alu_inc_pc_q  <= alu_inc_pc_d;
            rsp_lo_q      <= rsp_lo_d;
            rsp_hi_q      <= rsp_hi_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    assign bus.req_ready   = (state_q == StIdle);
    assign bus.busy        = (state_q != StIdle);
    assign bus.rsp_valid   = (state_q == StResp);
    assign bus.alu_reg1    = alu_reg1_q;
    assign bus.alu_reg2    = alu_reg2_q;
    assign bus.alu_control = alu_control_q;
    assign bus.alu_inc_pc  = alu_inc_pc_q;
    assign bus.rsp_lo      = rsp_lo_q;
    assign bus.rsp_hi      = rsp_hi_q;
    assign bus.rsp_tag     = rsp_tag_q;
    assign bus.rsp_err     = rsp_err_q;

    rsp_hold_a: assert property (@(posedge Clk) disable iff (Clear)
        bus.rsp_valid && !bus.rsp_ready |=> bus.rsp_valid &&
            $stable({bus.rsp_lo, bus.rsp_hi, bus.rsp_tag, bus.rsp_err}));

    ready_busy_a: assert property (@(posedge Clk) disable iff (Clear)
        bus.req_ready != bus.busy);

    inc_pc_busy_a: assert property (@(posedge Clk) disable iff (Clear)
        bus.alu_inc_pc |-> bus.busy);
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, vector table, response scoreboard,
// plus backpressure and mid-operation Clear sequences.
module tb_alu_op_sequencer;
    logic Clk   = 1'b0;
    logic Clear = 1'b1;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(
        .SIMPLE_WAIT(2),
        .MUL_WAIT   (4),
        .DIV_WAIT   (6)
    ) dut (
        .Clk  (Clk),
        .Clear(Clear),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    // z_hi is junk for single-word ops so forcing rsp_hi to 0 is observable.
    always_comb begin
        logic [63:0] prod;
        prod = 64'(bus.alu_reg1) * 64'(bus.alu_reg2);
        bus.alu_z_lo = 32'h0;
        bus.alu_z_hi = 32'hDEAD_BEEF;
        if (bus.alu_inc_pc) begin
            bus.alu_z_lo = bus.alu_reg2 + 32'd1;
        end else begin
            case (bus.alu_control)
                4'd0: begin
                    bus.alu_z_lo = (bus.alu_reg2 != 0) ? bus.alu_reg1 / bus.alu_reg2 : 32'h0;
                    bus.alu_z_hi = (bus.alu_reg2 != 0) ? bus.alu_reg1 % bus.alu_reg2 : 32'h0;
                end
                4'd1: {bus.alu_z_hi, bus.alu_z_lo} = prod;
                4'd2: bus.alu_z_lo = bus.alu_reg1 + bus.alu_reg2;
                4'd3: bus.alu_z_lo = bus.alu_reg1 - bus.alu_reg2;
                4'd4: bus.alu_z_lo = bus.alu_reg1 & bus.alu_reg2;
                4'd5: bus.alu_z_lo = bus.alu_reg1 | bus.alu_reg2;
                default: bus.alu_z_lo = 32'h0;
            endcase
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        err;
        int          lat;
    } vec_t;

    vec_t        vecs[12];
    vec_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_reg1 = 32'h0;
    logic [31:0] last_reg2 = 32'h0;
    logic [3:0]  last_ctrl = 4'h0;

    function automatic vec_t mk(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [3:0] tag,
                                logic [31:0] lo, logic [31:0] hi, logic err, int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.tag = tag;
        v.lo = lo; v.hi = hi; v.err = err; v.lat = lat;
        return v;
    endfunction

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},   64'(bus.req_ready),   64'd1);
        check({tag, "_rsp_valid"},   64'(bus.rsp_valid),   64'd0);
        check({tag, "_busy"},        64'(bus.busy),        64'd0);
        check({tag, "_alu_reg1"},    64'(bus.alu_reg1),    64'd0);
        check({tag, "_alu_reg2"},    64'(bus.alu_reg2),    64'd0);
        check({tag, "_alu_control"}, 64'(bus.alu_control), 64'd0);
        check({tag, "_alu_inc_pc"},  64'(bus.alu_inc_pc),  64'd0);
        check({tag, "_rsp_lo"},      64'(bus.rsp_lo),      64'd0);
        check({tag, "_rsp_hi"},      64'(bus.rsp_hi),      64'd0);
        check({tag, "_rsp_tag"},     64'(bus.rsp_tag),     64'd0);
        check({tag, "_rsp_err"},     64'(bus.rsp_err),     64'd0);
    endtask

    // One request through to response; hold > 0 keeps rsp_ready low for 1 + hold RESP cycles.
    task automatic do_op(input vec_t v, input int hold);
        vec_t       e;
        int         n;
        logic [3:0] ctrl;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge Clk); #1;
            n++;
        end
        check("req_ready_at_issue", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = v.op;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        bus.req_tag   = v.tag;
        bus.rsp_ready = (hold == 0);
        sb.push_back(v);
        @(posedge Clk); #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'($urandom);
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
        bus.req_tag   = 4'($urandom);
        ctrl = (v.op == 4'd12) ? 4'd2 : v.op;
        n = 1;
        while (!bus.rsp_valid && n < 40) begin
            check("busy_in_flight",      64'(bus.busy),        64'd1);
            check("req_ready_in_flight", 64'(bus.req_ready),   64'd0);
            check("alu_control_held",    64'(bus.alu_control), 64'(ctrl));
            check("alu_inc_pc_held",     64'(bus.alu_inc_pc),  64'(v.op == 4'd12));
            check("alu_reg1_held",       64'(bus.alu_reg1),    64'(v.a));
            check("alu_reg2_held",       64'(bus.alu_reg2),    64'(v.b));
            @(posedge Clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'(v.lat));
        e = sb.pop_front();
        check("rsp_lo",  64'(bus.rsp_lo),  64'(e.lo));
        check("rsp_hi",  64'(bus.rsp_hi),  64'(e.hi));
        check("rsp_tag", 64'(bus.rsp_tag), 64'(e.tag));
        check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
        if (e.err) begin
            check("err_alu_reg1_kept",   64'(bus.alu_reg1),    64'(last_reg1));
            check("err_alu_reg2_kept",   64'(bus.alu_reg2),    64'(last_reg2));
            check("err_alu_control_kept", 64'(bus.alu_control), 64'(last_ctrl));
            check("err_alu_inc_pc",      64'(bus.alu_inc_pc),  64'd0);
        end else begin
            check("resp_alu_control", 64'(bus.alu_control), 64'(ctrl));
            check("resp_alu_reg1",    64'(bus.alu_reg1),    64'(v.a));
        end
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            bus.req_op    = 4'd2;
            bus.req_a     = 32'd1;
            bus.req_b     = 32'd1;
            bus.req_tag   = 4'hF;
            @(posedge Clk); #1;
            check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_rsp_lo",    64'(bus.rsp_lo),    64'(e.lo));
            check("bp_rsp_hi",    64'(bus.rsp_hi),    64'(e.hi));
            check("bp_rsp_tag",   64'(bus.rsp_tag),   64'(e.tag));
            check("bp_rsp_err",   64'(bus.rsp_err),   64'(e.err));
            check("bp_req_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge Clk); #1;
        check("post_rsp_valid",  64'(bus.rsp_valid),  64'd0);
        check("post_req_ready",  64'(bus.req_ready),  64'd1);
        check("post_busy",       64'(bus.busy),       64'd0);
        check("post_alu_inc_pc", 64'(bus.alu_inc_pc), 64'd0);
        if (!v.err) begin
            last_reg1 = v.a;
            last_reg2 = v.b;
            last_ctrl = ctrl;
        end
    endtask

    initial begin
        logic seen_rsp;
        vecs[0]  = mk(4'd2,  32'd5,          32'd7,          4'd3,  32'd12,         32'd0, 1'b0, 4);
        vecs[1]  = mk(4'd1,  32'h0001_0000,  32'h0001_0000,  4'd1,  32'd0,          32'd1, 1'b0, 6);
        vecs[2]  = mk(4'd0,  32'd100,        32'd7,          4'd2,  32'd14,         32'd2, 1'b0, 8);
        vecs[3]  = mk(4'd0,  32'd100,        32'd0,          4'd4,  32'd0,          32'd0, 1'b1, 1);
        vecs[4]  = mk(4'd12, 32'h0000_1234,  32'h0000_0FFF,  4'd5,  32'h0000_1000,  32'd0, 1'b0, 4);
        vecs[5]  = mk(4'd14, 32'd9,          32'd9,          4'd6,  32'd0,          32'd0, 1'b1, 1);
        vecs[6]  = mk(4'd3,  32'd10,         32'd3,          4'd7,  32'd7,          32'd0, 1'b0, 4);
        vecs[7]  = mk(4'd4,  32'h0000_F0F0,  32'h0000_FF00,  4'd8,  32'h0000_F000,  32'd0, 1'b0, 4);
        vecs[8]  = mk(4'd1,  32'hFFFF_FFFF,  32'd2,          4'd9,  32'hFFFF_FFFE,  32'd1, 1'b0, 6);
        vecs[9]  = mk(4'd15, 32'd1,          32'd1,          4'd10, 32'd0,          32'd0, 1'b1, 1);
        vecs[10] = mk(4'd13, 32'd2,          32'd2,          4'd11, 32'd0,          32'd0, 1'b1, 1);
        vecs[11] = mk(4'd5,  32'h0000_000F,  32'h0000_00F0,  4'd12, 32'h0000_00FF,  32'd0, 1'b0, 4);

        bus.req_valid = 1'b0;
        bus.req_op    = 4'd0;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.req_tag   = 4'd0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Clear = 1'b0;
        check_reset_outputs("reset");

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i], 0);
        end

        do_op(mk(4'd2, 32'd20, 32'd22, 4'd11, 32'd42, 32'd0, 1'b0, 4), 4);

        // Abort a multiply two cycles into EXEC.
        bus.req_valid = 1'b1;
        bus.req_op    = 4'd1;
        bus.req_a     = 32'd3;
        bus.req_b     = 32'd5;
        bus.req_tag   = 4'd9;
        @(posedge Clk); #1;
        bus.req_valid = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("abort_busy_before_clear", 64'(bus.busy), 64'd1);
        Clear = 1'b1;
        @(posedge Clk); #1;
        Clear = 1'b0;
        check_reset_outputs("abort");
        seen_rsp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk); #1;
            if (bus.rsp_valid || bus.busy) seen_rsp = 1'b1;
        end
        check("abort_no_rsp", 64'(seen_rsp), 64'd0);
        last_reg1 = 32'h0;
        last_reg2 = 32'h0;
        last_ctrl = 4'h0;
        do_op(mk(4'd2, 32'd8, 32'd9, 4'd13, 32'd17, 32'd0, 1'b0, 4), 0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
